// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Constants and types shared by the inter-board UART transmitter and receiver.
//   MSG_WIDTH     : data bits per frame
//   CLKS_PER_BIT  : clocks each line bit is held (receiver oversampling)
//   START/STOP/IDLE line levels, transmitter FSM state type, and a helper
//   that sizes counters for a given range.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int MSG_WIDTH    = 20;
    localparam int CLKS_PER_BIT = 8;

    localparam logic START_BIT  = 1'b1;
    localparam logic STOP_BIT   = 1'b0;
    localparam logic IDLE_LEVEL = 1'b0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        GAP   = 3'd4
    } tx_state_t;

    // Width of a counter that holds 0..range_n-1 (at least one bit).
    function automatic int cnt_width(input int range_n);
        return (range_n > 1) ? $clog2(range_n) : 1;
    endfunction

endpackage

// File: rtl/uart_transmitter_piso.sv
// ---------------------------------------------------------------------------
// piso_register
// Parallel-load, shift-left register; the serial output is the MSB.
// Counterpart of the receiver's SIPO register.
// Ports:
//   clock      : system clock
//   reset      : synchronous active-high reset (clears contents)
//   i_load     : load i_data (has priority over i_en)
//   i_en       : shift left by one, zero fill
//   i_data     : parallel word
//   o_msb      : current MSB (bit on the line)
//   o_next_msb : bit that becomes the MSB after the next shift
// ---------------------------------------------------------------------------
module piso_register #(
    parameter int WIDTH = 20
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_msb,
    output logic             o_next_msb
);

    logic [WIDTH-1:0] r_data;

    // Shift register: load, shift or hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end else if (i_en) begin
            r_data <= {r_data[WIDTH-2:0], 1'b0};
        end else begin
            r_data <= r_data;
        end
    end

    assign o_msb      = r_data[WIDTH-1];
    assign o_next_msb = r_data[WIDTH-2];

endmodule

// File: rtl/uart_transmitter.sv
// ---------------------------------------------------------------------------
// uart_transmitter
// Parallel-to-serial UART transmitter feeding the 20-bit link receiver.
// Frame: start (1), MSG_WIDTH data bits MSB first, stop (0), then at least
// IDLE_BITS bit-times of idle-low line. A one-entry holding register accepts
// the next word while a frame is in flight.
// Ports:
//   clock     : system clock
//   reset     : synchronous active-high reset
//   message   : word to transmit, sampled when send && ready
//   send      : message valid
//   ready     : transmitter can accept a word this cycle (= holding reg empty)
//   busy      : frame in progress or holding register occupied
//   serialOut : registered serial line
// ---------------------------------------------------------------------------
module uart_transmitter #(
    parameter int MSG_WIDTH    = uart_pkg::MSG_WIDTH,
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
    parameter int IDLE_BITS    = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [MSG_WIDTH-1:0] message,
    input  logic                 send,
    output logic                 ready,
    output logic                 busy,
    output logic                 serialOut
);

    import uart_pkg::*;

    localparam int CNT_W    = cnt_width(CLKS_PER_BIT);
    localparam int IDX_W    = cnt_width(MSG_WIDTH);
    localparam int GAP_CLKS = IDLE_BITS * CLKS_PER_BIT;
    localparam int GAP_W    = cnt_width(GAP_CLKS);

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CLKS - 1);

    tx_state_t              r_state;
    tx_state_t              w_state_next;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [IDX_W-1:0]       r_bit_idx;
    logic [GAP_W-1:0]       r_gap_cnt;
    logic                   r_hold_valid;
    logic [MSG_WIDTH-1:0]   r_hold_data;
    logic                   r_serial_out;

    logic                   w_accept;
    logic                   w_direct_load;
    logic                   w_drain;
    logic                   w_piso_load;
    logic                   w_piso_shift;
    logic [MSG_WIDTH-1:0]   w_piso_data;
    logic                   w_piso_msb;
    logic                   w_piso_next_msb;
    logic                   w_bit_end;
    logic                   w_gap_end;
    logic                   w_line_next;

    assign ready     = !r_hold_valid;
    assign busy      = (r_state != IDLE) || r_hold_valid;
    assign serialOut = r_serial_out;

    assign w_accept  = send && ready;
    assign w_bit_end = (r_bit_cnt == BIT_LAST);
    assign w_gap_end = (r_gap_cnt == GAP_LAST);

    // A pending held word always wins the PISO; otherwise take the input word.
    assign w_piso_data = r_hold_valid ? r_hold_data : message;

    piso_register #(
        .WIDTH (MSG_WIDTH)
    ) u_piso (
        .clock      (clock),
        .reset      (reset),
        .i_load     (w_piso_load),
        .i_en       (w_piso_shift),
        .i_data     (w_piso_data),
        .o_msb      (w_piso_msb),
        .o_next_msb (w_piso_next_msb)
    );

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, PISO control and next line level.
    always_comb begin
        w_state_next  = r_state;
        w_piso_load   = 1'b0;
        w_piso_shift  = 1'b0;
        w_drain       = 1'b0;
        w_direct_load = 1'b0;
        w_line_next   = IDLE_LEVEL;

        case (r_state)
            IDLE: begin
                if (r_hold_valid) begin
                    w_state_next = START;
                    w_piso_load  = 1'b1;
                    w_drain      = 1'b1;
                end else if (w_accept) begin
                    w_state_next  = START;
                    w_piso_load   = 1'b1;
                    w_direct_load = 1'b1;
                end else begin
                    w_state_next = IDLE;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_next = DATA;
                end else begin
                    w_state_next = START;
                end
            end
            DATA: begin
                if (w_bit_end && (r_bit_idx == IDX_LAST)) begin
                    w_state_next = STOP;
                end else if (w_bit_end) begin
                    w_state_next = DATA;
                    w_piso_shift = 1'b1;
                end else begin
                    w_state_next = DATA;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_state_next = GAP;
                end else begin
                    w_state_next = STOP;
                end
            end
            GAP: begin
                if (w_gap_end && r_hold_valid) begin
                    w_state_next = START;
                    w_piso_load  = 1'b1;
                    w_drain      = 1'b1;
                end else if (w_gap_end) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = GAP;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // serialOut is registered, so it is driven from the state being
        // entered; in DATA a shift this cycle exposes the next MSB.
        case (w_state_next)
            START:   w_line_next = START_BIT;
            DATA:    w_line_next = w_piso_shift ? w_piso_next_msb : w_piso_msb;
            STOP:    w_line_next = STOP_BIT;
            GAP:     w_line_next = IDLE_LEVEL;
            IDLE:    w_line_next = IDLE_LEVEL;
            default: w_line_next = IDLE_LEVEL;
        endcase
    end

    // Bit-time, bit-index and gap counters; all rest at zero outside their state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_gap_cnt <= '0;
        end else begin
            if ((r_state == START) || (r_state == DATA) || (r_state == STOP)) begin
                r_bit_cnt <= w_bit_end ? '0 : (r_bit_cnt + CNT_W'(1));
            end else begin
                r_bit_cnt <= '0;
            end

            if ((r_state == DATA) && w_bit_end) begin
                r_bit_idx <= (r_bit_idx == IDX_LAST) ? '0 : (r_bit_idx + IDX_W'(1));
            end else if (r_state == DATA) begin
                r_bit_idx <= r_bit_idx;
            end else begin
                r_bit_idx <= '0;
            end

            if (r_state == GAP) begin
                r_gap_cnt <= w_gap_end ? '0 : (r_gap_cnt + GAP_W'(1));
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

    // Holding register: filled by any accepted word that cannot go straight
    // to the PISO, emptied when its word moves to the PISO.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
        end else if (w_drain) begin
            r_hold_valid <= 1'b0;
            r_hold_data  <= r_hold_data;
        end else if (w_accept && !w_direct_load) begin
            r_hold_valid <= 1'b1;
            r_hold_data  <= message;
        end else begin
            r_hold_valid <= r_hold_valid;
            r_hold_data  <= r_hold_data;
        end
    end

    // Registered line output.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_serial_out <= IDLE_LEVEL;
        end else begin
            r_serial_out <= w_line_next;
        end
    end

endmodule
